// File: rtl/pixel_feeder_pkg.sv
// Shared types and default geometry for the pixel feeder.
package pixel_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    localparam int unsigned WIDTH_DEF  = 800;
    localparam int unsigned HEIGHT_DEF = 600;
    localparam int unsigned BURST_DEF  = 8;
    localparam int unsigned DEPTH_DEF  = 64;
    localparam int unsigned STRIDE_DEF = 4096;

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead pixel FIFO: head is combinational from registered storage.
module pixel_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DW    = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DW-1:0]              data_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic          pop_en;

    assign count_o = wr_q - rd_q;
    assign empty_o = (wr_q == rd_q);
    assign pop_en  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(push_i);
            rd_q <= rd_q + (AW+1)'(pop_en);
        end
    end

    // The fetch credit scheme makes this unreachable; a hit means credit accounting is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && (count_o == (AW+1)'(DEPTH)) && !pop_en));

endmodule

// File: rtl/pixel_feeder.sv
// Framebuffer scanout: credit-limited burst fetcher feeding a pixel FIFO to the video sink.
module pixel_feeder
    import pixel_feeder_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned HEIGHT = HEIGHT_DEF,
    parameter int unsigned BURST  = BURST_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned STRIDE = STRIDE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] frame_addr,
    input  logic        frame_valid,
    output logic [31:0] rd_req_addr,
    output logic        rd_req_valid,
    input  logic        rd_req_ready,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    output logic [23:0] video,
    output logic        video_valid,
    input  logic        video_ready,
    output logic        frame_interrupt
);

    localparam int unsigned CW     = $clog2(DEPTH) + 1;
    localparam int unsigned CRW    = CW + 1;
    localparam int unsigned XW     = $clog2(WIDTH + 1);
    localparam int unsigned YW     = $clog2(HEIGHT + 1);
    localparam int unsigned PIXELS = WIDTH * HEIGHT;
    localparam int unsigned PW     = $clog2(PIXELS + 1);
    localparam logic [CRW-1:0] BURST_CR = CRW'(BURST);

    fetch_state_e   state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [31:0]    cur_base_q, cur_base_d;
    logic [31:0]    pend_base_q, pend_base_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [PW-1:0]  pix_q, pix_d;
    logic           irq_q, irq_d;

    logic [23:0]    fifo_head;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [CRW-1:0] credit;
    logic [CRW-1:0] credit_next;
    logic           accept;
    logic           pop;
    logic           last_x;
    logic           last_y;
    logic           last_pixel;
    logic [7:0]     unused_rd_hi;

    assign unused_rd_hi = rd_data[31:24];

    pixel_fifo #(
        .DEPTH (DEPTH),
        .DW    (24)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rd_data_valid),
        .data_i  (rd_data[23:0]),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign video_valid     = ~fifo_empty;
    assign video           = fifo_empty ? '0 : fifo_head;
    assign pop             = video_valid & video_ready;
    assign rd_req_valid    = (state_q == REQ);
    assign accept          = rd_req_valid & rd_req_ready;
    assign frame_interrupt = irq_q;

    assign rd_req_addr = cur_base_q + (32'(y_q) * STRIDE) + (32'(x_q) << 2);

    // Free FIFO slots not already promised to in-flight bursts.
    assign credit      = CRW'(DEPTH) - CRW'(fifo_count) - CRW'(outst_q);
    assign credit_next = credit - (accept ? BURST_CR : '0) + CRW'(pop);

    assign last_x     = (x_q == XW'(WIDTH - BURST));
    assign last_y     = (y_q == YW'(HEIGHT - 1));
    assign last_pixel = (pix_q == PW'(PIXELS - 1));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cur_base_d  = cur_base_q;
        pend_base_d = frame_valid ? frame_addr : pend_base_q;

        unique case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    state_d    = REQ;
                    cur_base_d = frame_addr;
                end
            end
            REQ: begin
                if (accept) begin
                    state_d = (credit_next >= BURST_CR) ? REQ : WAIT;
                end
            end
            WAIT: begin
                if (credit >= BURST_CR) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // A same-cycle strobe at the frame boundary still wins over the stored base.
        if (accept) begin
            if (last_x) begin
                x_d = '0;
                if (last_y) begin
                    y_d        = '0;
                    cur_base_d = pend_base_d;
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(BURST);
            end
        end

        outst_d = outst_q + (accept ? CW'(BURST) : '0) - CW'(rd_data_valid);

        pix_d = pix_q;
        if (pop) begin
            pix_d = last_pixel ? '0 : pix_q + PW'(1);
        end
        irq_d = pop & last_pixel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            cur_base_q  <= '0;
            pend_base_q <= '0;
            outst_q     <= '0;
            pix_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            cur_base_q  <= cur_base_d;
            pend_base_q <= pend_base_d;
            outst_q     <= outst_d;
            pix_q       <= pix_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_pixel_feeder.sv
// Scenario bench for pixel_feeder with a latency-5 memory model and arithmetic scanout reference.
module tb_pixel_feeder;

    localparam int unsigned WIDTH  = 800;
    localparam int unsigned HEIGHT = 3;
    localparam int unsigned BURST  = 8;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned STRIDE = 4096;
    localparam int unsigned PIXELS = WIDTH * HEIGHT;
    localparam int unsigned BPL    = WIDTH / BURST;
    localparam int unsigned BPF    = BPL * HEIGHT;
    localparam int unsigned MEM_LAT = 5;

    logic        clk;
    logic        rst_n;
    logic [31:0] frame_addr;
    logic        frame_valid;
    logic [31:0] rd_req_addr;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic [23:0] video;
    logic        video_valid;
    logic        video_ready;
    logic        frame_interrupt;

    int unsigned cyc;
    int          errors;
    int          checks;

    typedef struct {
        int unsigned rdy;
        logic [31:0] addr;
    } mw_t;

    mw_t         mq[$];
    logic [31:0] req_log[$];
    logic [23:0] pop_log[$];
    int unsigned pop_cyc[$];
    int unsigned irq_cyc[$];
    int          first_drive;
    int          first_vv;

    pixel_feeder #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .BURST  (BURST),
        .DEPTH  (DEPTH),
        .STRIDE (STRIDE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_addr      (frame_addr),
        .frame_valid     (frame_valid),
        .rd_req_addr     (rd_req_addr),
        .rd_req_valid    (rd_req_valid),
        .rd_req_ready    (rd_req_ready),
        .rd_data         (rd_data),
        .rd_data_valid   (rd_data_valid),
        .video           (video),
        .video_valid     (video_valid),
        .video_ready     (video_ready),
        .frame_interrupt (frame_interrupt)
    );

    function automatic logic [23:0] pix_of(input logic [31:0] a);
        return a[25:2] ^ {a[31:26], 18'h0} ^ 24'hA5C3E1;
    endfunction

    // k-th burst since the first frame started; frame 0 uses base0, later frames base1.
    function automatic logic [31:0] exp_addr(input int unsigned k, input logic [31:0] base0,
                                             input logic [31:0] base1);
        int unsigned f;
        int unsigned j;
        f = k / BPF;
        j = k % BPF;
        return ((f == 0) ? base0 : base1) + (j / BPL) * STRIDE + ((j % BPL) * BURST) * 4;
    endfunction

    initial begin
        clk = 1'b0;
        cyc = 0;
        forever begin
            #5 clk = ~clk;
            if (clk) cyc++;
        end
    end

    // Memory and observation process, all on the falling edge.
    initial begin
        rd_data_valid = 1'b0;
        rd_data       = '0;
        first_drive   = -1;
        first_vv      = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                rd_data_valid = 1'b0;
            end else begin
                if (rd_req_valid && rd_req_ready) begin
                    req_log.push_back(rd_req_addr);
                    for (int i = 0; i < int'(BURST); i++) begin
                        mq.push_back('{rdy: cyc + MEM_LAT, addr: rd_req_addr + 32'(i * 4)});
                    end
                end
                if (video_valid && video_ready) begin
                    pop_log.push_back(video);
                    pop_cyc.push_back(cyc);
                end
                if (video_valid === 1'b1 && first_vv < 0) first_vv = int'(cyc);
                if (frame_interrupt) irq_cyc.push_back(cyc);
                if (mq.size() > 0 && mq[0].rdy <= cyc) begin
                    rd_data       = {8'($urandom), pix_of(mq[0].addr)};
                    rd_data_valid = 1'b1;
                    if (first_drive < 0) first_drive = int'(cyc);
                    void'(mq.pop_front());
                end else begin
                    rd_data_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_req_valid got=%b exp=0", rd_req_valid); end
        checks++; if (video_valid !== 1'b0) begin errors++; $display("FAIL reset_video_valid got=%b exp=0", video_valid); end
        checks++; if (frame_interrupt !== 1'b0) begin errors++; $display("FAIL reset_frame_interrupt got=%b exp=0", frame_interrupt); end
        checks++; if (rd_req_addr !== 32'h0) begin errors++; $display("FAIL reset_rd_req_addr got=%h exp=00000000", rd_req_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("FAIL post_reset_rd_req_valid got=%b exp=0", rd_req_valid); end
    endtask

    task automatic test_idle;
        int bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            rd_req_ready = 1'($urandom);
            video_ready  = 1'($urandom);
            if (rd_req_valid !== 1'b0 || video_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_outputs got=%0d active cycles exp=0", bad); end
    endtask

    task automatic test_stall;
        int late_valid;
        late_valid = 0;
        @(posedge clk); #1;
        rd_req_ready = 1'b1;
        video_ready  = 1'b0;
        frame_addr   = 32'h1000_0000;
        frame_valid  = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        frame_addr  = $urandom;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (i >= 100 && rd_req_valid !== 1'b0) late_valid++;
        end
        checks++; if (req_log.size() != BURST) begin errors++; $display("FAIL stall_burst_count got=%0d exp=%0d", req_log.size(), BURST); end
        checks++;
        if (req_log.size() < 8) begin errors++; $display("FAIL stall_last_addr got=missing exp=100000e0"); end
        else if (req_log[7] !== 32'h1000_00E0) begin errors++; $display("FAIL stall_last_addr got=%h exp=100000e0", req_log[7]); end
        checks++; if (late_valid != 0) begin errors++; $display("FAIL stall_req_quiet got=%0d valid cycles exp=0", late_valid); end
        checks++; if (video_valid !== 1'b1) begin errors++; $display("FAIL stall_video_valid got=%b exp=1", video_valid); end
        checks++; if (pop_log.size() != 0) begin errors++; $display("FAIL stall_no_pops got=%0d exp=0", pop_log.size()); end
        checks++; if (first_vv != first_drive + 1) begin errors++; $display("FAIL push_latency got=%0d exp=%0d", first_vv, first_drive + 1); end
    endtask

    task automatic test_stream;
        logic        last_v;
        logic        last_r;
        logic [31:0] last_a;
        int          hold_bad;
        int          bad;
        bit          s1;
        bit          s2;
        int unsigned n_pop;
        int unsigned n_req;
        int unsigned n_irq;
        logic [31:0] a;
        last_v = 1'b0; last_r = 1'b1; last_a = '0;
        hold_bad = 0; s1 = 0; s2 = 0;
        for (int it = 0; it < 30000 && pop_log.size() < 2 * PIXELS + 50; it++) begin
            @(posedge clk); #1;
            if (last_v && !last_r && (rd_req_valid !== 1'b1 || rd_req_addr !== last_a)) hold_bad++;
            frame_valid = 1'b0;
            if (!s1 && req_log.size() >= 100) begin
                frame_addr = 32'h1800_0000; frame_valid = 1'b1; s1 = 1;
            end else if (!s2 && req_log.size() >= 150) begin
                frame_addr = 32'h2000_0000; frame_valid = 1'b1; s2 = 1;
            end
            rd_req_ready = ($urandom_range(0, 3) != 0);
            video_ready  = ($urandom_range(0, 7) != 0);
            last_v = rd_req_valid; last_r = rd_req_ready; last_a = rd_req_addr;
        end
        frame_valid  = 1'b0;
        rd_req_ready = 1'b1;
        video_ready  = 1'b1;
        n_pop = pop_log.size();
        n_req = req_log.size();

        checks++; if (n_pop < 2 * PIXELS + 50) begin errors++; $display("FAIL stream_timeout got=%0d pops exp>=%0d", n_pop, 2 * PIXELS + 50); end
        bad = 0;
        for (int k = 0; k < int'(n_req); k++)
            if (req_log[k] !== exp_addr(k, 32'h1000_0000, 32'h2000_0000)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL req_seq got=%0d wrong addresses exp=0", bad); end
        checks++;
        if (n_req <= BPF) begin errors++; $display("FAIL addr_points got=%0d requests exp>%0d", n_req, BPF); end
        else if (req_log[99] !== 32'h1000_0C60 || req_log[100] !== 32'h1000_1000 || req_log[BPF] !== 32'h2000_0000) begin
            errors++;
            $display("FAIL addr_points got=%h/%h/%h exp=10000c60/10001000/20000000", req_log[99], req_log[100], req_log[BPF]);
        end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL req_hold got=%0d unstable cycles exp=0", hold_bad); end
        bad = 0;
        for (int p = 0; p < int'(n_pop); p++) begin
            a = exp_addr(p / BURST, 32'h1000_0000, 32'h2000_0000) + 32'((p % BURST) * 4);
            if (pop_log[p] !== pix_of(a)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL pix_seq got=%0d wrong pixels exp=0", bad); end
        n_irq = n_pop / PIXELS;
        checks++; if (irq_cyc.size() != n_irq) begin errors++; $display("FAIL irq_count got=%0d exp=%0d", irq_cyc.size(), n_irq); end
        bad = 0;
        for (int m = 0; m < int'(n_irq) && m < irq_cyc.size(); m++)
            if (irq_cyc[m] != pop_cyc[(m + 1) * PIXELS - 1] + 1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL irq_timing got=%0d misplaced pulses exp=0", bad); end
    endtask

    task automatic test_reset_mid;
        int waited;
        int bad;
        waited = 0;
        while (mq.size() == 0 && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        checks++; if (mq.size() == 0) begin errors++; $display("FAIL mid_outstanding got=0 words exp>0"); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_rd_req_valid got=%b exp=0", rd_req_valid); end
        checks++; if (video_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_video_valid got=%b exp=0", video_valid); end
        checks++; if (frame_interrupt !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got=%b exp=0", frame_interrupt); end
        checks++; if (rd_req_addr !== 32'h0) begin errors++; $display("FAIL mid_reset_addr got=%h exp=00000000", rd_req_addr); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_log.delete(); pop_log.delete(); pop_cyc.delete(); irq_cyc.delete();
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (rd_req_valid !== 1'b0 || video_valid !== 1'b0 || frame_interrupt !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_after_reset got=%0d active cycles exp=0", bad); end
        frame_addr  = 32'h4000_0000;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        waited = 0;
        while (pop_log.size() < 16 && waited < 300) begin
            @(posedge clk); #1; waited++;
        end
        checks++;
        if (req_log.size() < 2) begin errors++; $display("FAIL restart_addr got=%0d requests exp>=2", req_log.size()); end
        else if (req_log[0] !== 32'h4000_0000 || req_log[1] !== 32'h4000_0020) begin
            errors++; $display("FAIL restart_addr got=%h/%h exp=40000000/40000020", req_log[0], req_log[1]);
        end
        checks++;
        if (pop_log.size() < 16) begin errors++; $display("FAIL restart_pixels got=%0d pops exp>=16", pop_log.size()); end
        else if (pop_log[0] !== pix_of(32'h4000_0000) || pop_log[15] !== pix_of(32'h4000_003C)) begin
            errors++; $display("FAIL restart_pixels got=%h/%h exp=%h/%h", pop_log[0], pop_log[15],
                               pix_of(32'h4000_0000), pix_of(32'h4000_003C));
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        frame_addr   = '0;
        frame_valid  = 1'b0;
        rd_req_ready = 1'b0;
        video_ready  = 1'b0;
        test_reset;
        test_idle;
        test_stall;
        test_stream;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
